// File: rtl/apb_spi_master.sv
// APB-programmed SPI master (mode 0, MSB first): shifts a 10-bit command frame out on MOSI
// and optionally clocks in an 8-bit read response from MISO into RXDATA.
module apb_spi_master #(
  parameter int FRAME_W = 10,
  parameter int RD_W    = 8,
  parameter int DIV_W   = 8
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [7:0]  PADDR,
  input  logic [7:0]  PWDATA,
  output logic [15:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        SCLK,
  output logic        SS_n,
  output logic        MOSI,
  input  logic        MISO,
  output logic        done_irq
);

  localparam int CNT_W = $clog2(FRAME_W + RD_W + 1);
  localparam logic [CNT_W-1:0] N_BASE = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] N_EXT  = CNT_W'(FRAME_W + RD_W);

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_STATUS = 8'h04;
  localparam logic [7:0] A_TX_LO  = 8'h08;
  localparam logic [7:0] A_TX_HI  = 8'h0C;
  localparam logic [7:0] A_RXDATA = 8'h10;
  localparam logic [7:0] A_CLKDIV = 8'h14;

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

  state_t               state;
  logic                 rd_ext;
  logic                 irq_en;
  logic                 done;
  logic [7:0]           tx_lo;
  logic [FRAME_W-9:0]   tx_hi;
  logic [DIV_W-1:0]     clkdiv;
  logic [DIV_W-1:0]     cnt;
  logic [FRAME_W-1:0]   tx_sr;
  logic [FRAME_W-1:0]   rx_sr;
  logic [FRAME_W-1:0]   rxdata;
  logic [CNT_W-1:0]     rises;
  logic [CNT_W-1:0]     n_rises;
  logic                 sclk_r;
  logic                 ss_n_r;
  logic                 mosi_r;

  logic busy;
  logic access;
  logic wr;
  logic mapped;
  logic wr_err;
  logic wr_ok;
  logic start;
  logic done_clr;
  logic phase_end;

  assign busy      = (state != IDLE);
  assign access    = PSEL & PENABLE;
  assign wr        = access & PWRITE;
  assign phase_end = (cnt == '0);
  assign n_rises   = rd_ext ? N_EXT : N_BASE;

  // Address decode and error classification; an errored write is dropped entirely.
  always_comb begin
    mapped = 1'b1;
    wr_err = 1'b0;
    case (PADDR)
      A_CTRL, A_TX_LO, A_TX_HI, A_CLKDIV: wr_err = busy;
      A_STATUS:                           wr_err = ~PWDATA[1];
      A_RXDATA:                           wr_err = 1'b1;
      default: begin
        mapped = 1'b0;
        wr_err = 1'b1;
      end
    endcase
  end

  assign PSLVERR  = access & (~mapped | (PWRITE & wr_err));
  assign wr_ok    = wr & ~wr_err;
  assign start    = wr_ok & (PADDR == A_CTRL) & PWDATA[0];
  assign done_clr = wr_ok & (PADDR == A_STATUS) & PWDATA[1];
  assign PREADY   = 1'b1;

  always_comb begin
    PRDATA = '0;
    if (PSEL && !PWRITE) begin
      case (PADDR)
        A_CTRL:   PRDATA = {13'b0, irq_en, rd_ext, 1'b0};
        A_STATUS: PRDATA = {14'b0, done, busy};
        A_TX_LO:  PRDATA = {8'b0, tx_lo};
        A_TX_HI:  PRDATA = 16'(tx_hi);
        A_RXDATA: PRDATA = 16'(rxdata);
        A_CLKDIV: PRDATA = 16'(clkdiv);
        default:  PRDATA = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rd_ext <= 1'b0;
      irq_en <= 1'b0;
      tx_lo  <= '0;
      tx_hi  <= '0;
      clkdiv <= '0;
    end else if (wr_ok) begin
      case (PADDR)
        A_CTRL: begin
          rd_ext <= PWDATA[1];
          irq_en <= PWDATA[2];
        end
        A_TX_LO:  tx_lo  <= PWDATA;
        A_TX_HI:  tx_hi  <= PWDATA[FRAME_W-9:0];
        A_CLKDIV: clkdiv <= PWDATA[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // Half-period timer: every phase (LEAD, each SCLK level, TRAIL, GAP) lasts CLKDIV+1 cycles.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == IDLE) begin
      if (start) cnt <= clkdiv;
    end else if (phase_end) begin
      cnt <= clkdiv;
    end else begin
      cnt <= cnt - DIV_W'(1);
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state  <= IDLE;
      tx_sr  <= '0;
      rx_sr  <= '0;
      rxdata <= '0;
      rises  <= '0;
      sclk_r <= 1'b0;
      ss_n_r <= 1'b1;
      mosi_r <= 1'b0;
      done   <= 1'b0;
    end else begin
      if (done_clr) done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            tx_sr  <= {tx_hi, tx_lo};
            mosi_r <= tx_hi[FRAME_W-9];
            ss_n_r <= 1'b0;
            rises  <= '0;
            done   <= 1'b0;
            state  <= LEAD;
          end
        end
        LEAD: begin
          if (phase_end) begin
            sclk_r <= 1'b1;
            rx_sr  <= {rx_sr[FRAME_W-2:0], MISO};
            rises  <= rises + CNT_W'(1);
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (phase_end) begin
            if (sclk_r) begin
              sclk_r <= 1'b0;
              if (rises == n_rises) begin
                mosi_r <= 1'b0;
                state  <= TRAIL;
              end else begin
                // Zero fill means the read extension drives MOSI=0 with no extra logic.
                mosi_r <= tx_sr[FRAME_W-2];
                tx_sr  <= {tx_sr[FRAME_W-2:0], 1'b0};
              end
            end else begin
              sclk_r <= 1'b1;
              rx_sr  <= {rx_sr[FRAME_W-2:0], MISO};
              rises  <= rises + CNT_W'(1);
            end
          end
        end
        TRAIL: begin
          if (phase_end) begin
            ss_n_r <= 1'b1;
            state  <= GAP;
          end
        end
        GAP: begin
          if (phase_end) begin
            rxdata <= rd_ext ? {{(FRAME_W-RD_W){1'b0}}, rx_sr[RD_W-1:0]} : rx_sr;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign SCLK     = sclk_r;
  assign SS_n     = ss_n_r;
  assign MOSI     = mosi_r;
  assign done_irq = done & irq_en;

endmodule
